// File: rtl/sobel_frame_ctrl_if.sv
// Bus bundle for sobel_frame_ctrl: pixel source, frame memory, filter core and result stream.
// The err signal exists only when SOBEL_FRAME_CTRL_TIMEOUT_EN is defined.
interface sobel_frame_ctrl_if;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        mem_we;
  logic [18:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        win_req;
  logic [18:0] win_addr;
  logic [71:0] win_data;
  logic [71:0] filt_in;
  logic        filt_strobe;
  logic [7:0]  filt_out;
  logic        filt_valid;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        done;
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
  logic        err;

  modport master (
    input  start, pix_in, pix_valid, win_data, filt_out, filt_valid, res_ready,
    output pix_ready, mem_we, mem_waddr, mem_wdata, win_req, win_addr,
           filt_in, filt_strobe, res_data, res_valid, busy, done, err
  );
  modport slave (
    output start, pix_in, pix_valid, win_data, filt_out, filt_valid, res_ready,
    input  pix_ready, mem_we, mem_waddr, mem_wdata, win_req, win_addr,
           filt_in, filt_strobe, res_data, res_valid, busy, done, err
  );
`else
  modport master (
    input  start, pix_in, pix_valid, win_data, filt_out, filt_valid, res_ready,
    output pix_ready, mem_we, mem_waddr, mem_wdata, win_req, win_addr,
           filt_in, filt_strobe, res_data, res_valid, busy, done
  );
  modport slave (
    output start, pix_in, pix_valid, win_data, filt_out, filt_valid, res_ready,
    input  pix_ready, mem_we, mem_waddr, mem_wdata, win_req, win_addr,
           filt_in, filt_strobe, res_data, res_valid, busy, done
  );
`endif
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: load a frame, then fetch/filter/emit every 3x3 window.
// Optional WAIT_FILT watchdog and sticky err output: define SOBEL_FRAME_CTRL_TIMEOUT_EN.
module sobel_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic            clk,
  input  logic            reset,
  sobel_frame_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_CAPT, S_FILT, S_WAIT_FILT, S_EMIT, S_DONE
  } state_t;

  localparam logic [18:0] LAST_PIX = 19'(IMG_W * IMG_H - 1);
  localparam logic [18:0] ROW_STEP = 19'(IMG_W);
  localparam logic [9:0]  LAST_COL = 10'(IMG_W - 3);
  localparam logic [8:0]  LAST_ROW = 9'(IMG_H - 3);

  state_t      r_state;
  state_t      w_next;
  logic [18:0] r_wcnt;
  logic [18:0] r_row_base;
  logic [9:0]  r_col;
  logic [8:0]  r_row;
  logic [71:0] r_filt_in;
  logic [7:0]  r_res_data;
  logic        r_res_valid;
  logic        w_pix_fire;
  logic        w_filt_fire;
  logic        w_res_fire;
  logic        w_frame_start;
  logic        w_last_win;
  logic        w_timeout;

  assign w_frame_start = (r_state == S_IDLE) && bus.start;
  assign w_last_win    = (r_row == LAST_ROW) && (r_col == LAST_COL);

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;

  // A late filt_valid on the final watchdog cycle still wins over the timeout.
  assign w_timeout = (r_state == S_WAIT_FILT) && (r_wdog == 8'd254) && !bus.filt_valid;
  assign bus.err   = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= 8'd0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_WAIT_FILT) ? r_wdog + 8'd1 : 8'd0;
      if (w_frame_start)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pix_fire  = 1'b0;
    w_filt_fire = 1'b0;
    w_res_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
        else           w_next = S_IDLE;
      end
      S_LOAD: begin
        w_pix_fire = bus.pix_valid;
        if (bus.pix_valid && (r_wcnt == LAST_PIX)) w_next = S_FETCH;
        else                                      w_next = S_LOAD;
      end
      S_FETCH: w_next = S_CAPT;
      S_CAPT:  w_next = S_FILT;
      S_FILT:  w_next = S_WAIT_FILT;
      S_WAIT_FILT: begin
        w_filt_fire = bus.filt_valid || w_timeout;
        if (w_filt_fire) w_next = S_EMIT;
        else             w_next = S_WAIT_FILT;
      end
      S_EMIT: begin
        w_res_fire = bus.res_ready;
        if (!bus.res_ready)  w_next = S_EMIT;
        else if (w_last_win) w_next = S_DONE;
        else                 w_next = S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row base is tracked incrementally so no multiplier is needed for win_addr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt     <= 19'd0;
      r_row_base <= 19'd0;
      r_col      <= 10'd0;
      r_row      <= 9'd0;
    end else if (w_frame_start) begin
      r_wcnt     <= 19'd0;
      r_row_base <= 19'd0;
      r_col      <= 10'd0;
      r_row      <= 9'd0;
    end else if (w_pix_fire) begin
      r_wcnt <= r_wcnt + 19'd1;
    end else if (w_res_fire && !w_last_win) begin
      if (r_col == LAST_COL) begin
        r_col      <= 10'd0;
        r_row      <= r_row + 9'd1;
        r_row_base <= r_row_base + ROW_STEP;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt_in   <= 72'd0;
      r_res_data  <= 8'h00;
      r_res_valid <= 1'b0;
    end else begin
      if (r_state == S_CAPT)
        r_filt_in <= bus.win_data;
      if (w_filt_fire) begin
        r_res_data  <= w_timeout ? 8'h00 : bus.filt_out;
        r_res_valid <= 1'b1;
      end else if (w_res_fire) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.pix_ready   = (r_state == S_LOAD);
  assign bus.mem_we      = w_pix_fire;
  assign bus.mem_waddr   = r_wcnt;
  assign bus.mem_wdata   = w_pix_fire ? bus.pix_in : 8'h00;
  assign bus.win_req     = (r_state == S_FETCH);
  assign bus.win_addr    = r_row_base + {9'd0, r_col};
  assign bus.filt_in     = r_filt_in;
  assign bus.filt_strobe = (r_state == S_FILT);
  assign bus.res_data    = r_res_data;
  assign bus.res_valid   = r_res_valid;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
endmodule
